// File: rtl/sparse_pe_row.sv
// Row compute stage: 9-lane MAC into a per-column psum buffer, then streams the finished row out.
// Optional build macro SPARSE_PE_RELU_EN clamps negative psums to zero on the drain output only.
module sparse_pe_row #(
  parameter int DATA_WIDTH     = 8,
  parameter int LANES          = 9,
  parameter int IDX_WIDTH      = 4,
  parameter int NUM_COL        = 16,
  parameter int PSUM_WIDTH     = 20,
  parameter int GROUPS_PER_ROW = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic [DATA_WIDTH*LANES-1:0] parallel_out,
  input  logic [DATA_WIDTH-1:0]       serial_out,
  input  logic [IDX_WIDTH-1:0]        act_index,
  input  logic [IDX_WIDTH:0]          row_index,
  input  logic [IDX_WIDTH-1:0]        row_val_num,
  input  logic                        zero_flag,
  output logic [IDX_WIDTH-1:0]        cnt,
  output logic                        row_finish_done_0,
  output logic                        row_finish_done_1,
  output logic                        row_cal_done,
  output logic                        psum_valid,
  input  logic                        psum_ready,
  output logic [PSUM_WIDTH-1:0]       psum_data,
  output logic [IDX_WIDTH-1:0]        psum_col,
  output logic [IDX_WIDTH:0]          psum_row,
  output logic                        busy
);

  // state | meaning
  // IDLE  | waiting for en
  // RUN   | one element per cycle, groups counted
  // FLUSH | last element leaves the MAC pipeline
  // DRAIN | psum buffer streamed out column by column
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DRAIN} state_t;

  localparam int GRP_W  = $clog2(GROUPS_PER_ROW + 1);
  localparam int PROD_W = 2 * DATA_WIDTH;

  state_t state, state_next;

  logic [PSUM_WIDTH-1:0] psum_mem [NUM_COL];
  logic [GRP_W-1:0]      grp_cnt;
  logic [IDX_WIDTH-1:0]  drain_col;

  logic                  s1_valid;
  logic [IDX_WIDTH-1:0]  s1_idx;
  logic [PSUM_WIDTH-1:0] s1_sum;
  logic [PSUM_WIDTH-1:0] s1_old;

  logic [PSUM_WIDTH-1:0] prod_sum;
  logic [PSUM_WIDTH-1:0] wr_val;
  logic [PSUM_WIDTH-1:0] rd_old;
  logic [PSUM_WIDTH-1:0] drain_raw;
  logic [PSUM_WIDTH-1:0] drain_val;

  logic mac_fire, group_done, last_group, xfer, last_xfer;

  always_comb begin
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    logic signed [PROD_W-1:0] prod;
    prod_sum = '0;
    a_ext    = {{DATA_WIDTH{serial_out[DATA_WIDTH-1]}}, serial_out};
    for (int k = 0; k < LANES; k++) begin
      b_ext    = {{DATA_WIDTH{parallel_out[k*DATA_WIDTH+DATA_WIDTH-1]}},
                  parallel_out[k*DATA_WIDTH +: DATA_WIDTH]};
      prod     = a_ext * b_ext;
      prod_sum = prod_sum + {{(PSUM_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};
    end
  end

  // Stage 2 writes s1_idx this cycle; a stage-1 read of the same column takes the new value.
  assign wr_val = s1_old + s1_sum;
  assign rd_old = (s1_valid && (s1_idx == act_index)) ? wr_val : psum_mem[act_index];

  assign mac_fire   = (state == S_RUN) && !zero_flag;
  assign group_done = (state == S_RUN) && (zero_flag || (cnt == row_val_num));
  assign last_group = group_done && (grp_cnt == GRP_W'(GROUPS_PER_ROW - 1));
  assign xfer       = (state == S_DRAIN) && psum_ready;
  assign last_xfer  = xfer && (drain_col == IDX_WIDTH'(NUM_COL - 1));

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (en) state_next = S_RUN;
      S_RUN:   if (last_group) state_next = S_FLUSH;
      S_FLUSH: state_next = S_DRAIN;
      S_DRAIN: if (last_xfer) state_next = S_RUN;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      grp_cnt   <= '0;
      drain_col <= '0;
      psum_row  <= '0;
      s1_valid  <= 1'b0;
      s1_idx    <= '0;
      s1_sum    <= '0;
      s1_old    <= '0;
      for (int c = 0; c < NUM_COL; c++) psum_mem[c] <= '0;
    end else begin
      state    <= state_next;
      s1_valid <= mac_fire;
      if (mac_fire) begin
        s1_idx <= act_index;
        s1_sum <= prod_sum;
        s1_old <= rd_old;
      end
      if (s1_valid) psum_mem[s1_idx] <= wr_val;

      if (state == S_RUN) begin
        if (group_done) cnt <= '0;
        else            cnt <= cnt + IDX_WIDTH'(1);
      end

      if (last_xfer)       grp_cnt <= '0;
      else if (group_done) grp_cnt <= grp_cnt + GRP_W'(1);

      if (last_group) psum_row <= row_index;

      // Pipeline is empty in DRAIN, so the clear never collides with a stage-2 write.
      if (xfer) begin
        psum_mem[drain_col] <= '0;
        drain_col           <= last_xfer ? '0 : drain_col + IDX_WIDTH'(1);
      end
    end
  end

  assign drain_raw = psum_mem[drain_col];

`ifdef SPARSE_PE_RELU_EN
  assign drain_val = drain_raw[PSUM_WIDTH-1] ? '0 : drain_raw;
`else
  assign drain_val = drain_raw;
`endif

  assign psum_valid        = (state == S_DRAIN);
  assign psum_data         = psum_valid ? drain_val : '0;
  assign psum_col          = drain_col;
  assign row_finish_done_0 = group_done;
  assign row_finish_done_1 = 1'b0;
  assign row_cal_done      = last_xfer;
  assign busy              = (state != S_IDLE);

endmodule
